// File: rtl/cia_pkg.sv
// Shared definitions for the CIA bus sequencer: register indices,
// sequencer state encoding and default E-clock divider settings.
// Optional build macro used by this slice: CIA_POSTED_WRITE_EN.
package cia_pkg;

    // E clock: 10 clk7_en periods per E period, high for the last 4.
    localparam int E_DIV_DEF  = 10;
    localparam int E_HIGH_DEF = 4;

    // CIA register indices that the timer and control blocks decode.
    localparam logic [3:0] CIA_TALO = 4'h4;
    localparam logic [3:0] CIA_TAHI = 4'h5;
    localparam logic [3:0] CIA_TBLO = 4'h6;
    localparam logic [3:0] CIA_TBHI = 4'h7;
    localparam logic [3:0] CIA_CRA  = 4'hE;
    localparam logic [3:0] CIA_CRB  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } cia_state_t;

    // One-hot register select from a 4-bit register index.
    function automatic logic [15:0] cia_onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/cia_eclk_gen.sv
// E-clock divider. Counts clk7_en strobes modulo E_DIV and derives the
// E level (high for the last E_HIGH counts) and a one-count timer enable
// on the final count of each E period.
module cia_eclk_gen
    import cia_pkg::*;
#(
    parameter int E_DIV  = E_DIV_DEF,
    parameter int E_HIGH = E_HIGH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    output logic [3:0] ecnt,
    output logic       e_phase,
    output logic       eclk
);

    localparam logic [3:0] ECNT_LAST = 4'(E_DIV - 1);
    localparam logic [3:0] ECNT_HIGH = 4'(E_DIV - E_HIGH);

    logic [3:0] ecnt_q;
    logic [3:0] ecnt_d;

    // Next count: advance only on clk7_en, wrap at the end of the E period.
    always_comb begin
        ecnt_d = ecnt_q;
        if (clk7_en) begin
            if (ecnt_q == ECNT_LAST) begin
                ecnt_d = 4'd0;
            end else begin
                ecnt_d = ecnt_q + 4'd1;
            end
        end
    end

    // Divider register; reset wins over clk7_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecnt_q <= 4'd0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign ecnt    = ecnt_q;
    assign e_phase = (ecnt_q >= ECNT_HIGH);
    assign eclk    = (ecnt_q == ECNT_LAST);

endmodule

// File: rtl/cia_bus_sequencer.sv
// CPU-to-CIA access sequencer. Generates the E clock, holds each CPU
// request until a fixed E phase, then issues a single one-period register
// strobe and acknowledges the CPU.
//
// state  | meaning
// IDLE   | no access in flight; req sampled here only
// WAIT   | request latched, waiting for ecnt == ACC_PHASE-1
// ACCESS | strobe period (ecnt == ACC_PHASE); read data captured on exit
// DONE   | ack high for one clk7_en period
//
// Build option CIA_POSTED_WRITE_EN: writes ack one clk7_en period after
// acceptance (during WAIT), still perform their strobe in the normal
// ACCESS window, and return straight to IDLE with no second ack.
module cia_bus_sequencer
    import cia_pkg::*;
#(
    parameter int E_DIV     = E_DIV_DEF,
    parameter int E_HIGH    = E_HIGH_DEF,
    parameter int ACC_PHASE = E_DIV_DEF - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        req,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        ack,
    output logic [15:0] reg_sel,
    output logic        wr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        eclk,
    output logic        e_phase
);

    // The WAIT exit is one count ahead so ACCESS lands exactly on ACC_PHASE.
    localparam logic [3:0] ECNT_PRE_ACC = 4'(ACC_PHASE - 1);

    logic [3:0] ecnt;

    cia_state_t state_q, state_d;
    logic       rw_q,    rw_d;
    logic [3:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] dout_q,  dout_d;
`ifdef CIA_POSTED_WRITE_EN
    logic       post_ack_q, post_ack_d;
`endif

    cia_eclk_gen #(
        .E_DIV  (E_DIV),
        .E_HIGH (E_HIGH)
    ) u_eclk_gen (
        .clk     (clk),
        .reset   (reset),
        .clk7_en (clk7_en),
        .ecnt    (ecnt),
        .e_phase (e_phase),
        .eclk    (eclk)
    );

    // Next-state and request latching; nothing moves unless clk7_en is high.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
`ifdef CIA_POSTED_WRITE_EN
        post_ack_d = post_ack_q;
`endif
        if (clk7_en) begin
`ifdef CIA_POSTED_WRITE_EN
            post_ack_d = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_WAIT;
                        rw_d    = rw;
                        addr_d  = addr;
                        data_d  = cpu_din;
`ifdef CIA_POSTED_WRITE_EN
                        post_ack_d = ~rw;
`endif
                    end
                end
                ST_WAIT: begin
                    if (ecnt == ECNT_PRE_ACC) begin
                        state_d = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (rw_q) begin
                        dout_d = bus_din;
                    end
`ifdef CIA_POSTED_WRITE_EN
                    // A posted write was already acknowledged.
                    state_d = rw_q ? ST_DONE : ST_IDLE;
`else
                    state_d = ST_DONE;
`endif
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and latched request registers; reset aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= 4'd0;
            data_q  <= 8'd0;
            dout_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
        end
    end

`ifdef CIA_POSTED_WRITE_EN
    // Early write acknowledge flag, high for the first WAIT period.
    always_ff @(posedge clk) begin
        if (reset) begin
            post_ack_q <= 1'b0;
        end else begin
            post_ack_q <= post_ack_d;
        end
    end
`endif

    // Register bus drive: only during ACCESS, otherwise fully quiet.
    always_comb begin
        reg_sel  = 16'h0000;
        wr       = 1'b0;
        bus_dout = 8'h00;
        if (state_q == ST_ACCESS) begin
            reg_sel  = cia_onehot(addr_q);
            wr       = ~rw_q;
            bus_dout = data_q;
        end
    end

`ifdef CIA_POSTED_WRITE_EN
    assign ack = (state_q == ST_DONE) | post_ack_q;
`else
    assign ack = (state_q == ST_DONE);
`endif
    assign cpu_dout = dout_q;

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Self-checking bench for cia_bus_sequencer. Table vectors are replayed
// with clk7_en tied high and pulsed 1-in-4; expected strobes and acks are
// queued at request time and compared as the DUT produces them.
module tb_cia_bus_sequencer;
    import cia_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        req;
    logic        rw;
    logic [3:0]  addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        ack;
    logic [15:0] reg_sel;
    logic        wr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        eclk;
    logic        e_phase;

    always #5 clk = ~clk;

    cia_bus_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .ack      (ack),
        .reg_sel  (reg_sel),
        .wr       (wr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .eclk     (eclk),
        .e_phase  (e_phase)
    );

    typedef struct {
        logic        rw;
        logic [3:0]  addr;
        logic [7:0]  din;
        logic [7:0]  bdin;
        int          start_ecnt;
        int          exp_lat;
        logic [15:0] exp_sel;
    } vec_t;

    typedef struct {
        int          req_edge;
        int          exp_lat;
        logic [7:0]  exp_dout;
        logic [15:0] exp_sel;
        logic        exp_wr;
        logic [7:0]  exp_bus;
    } sb_t;

    sb_t  ack_q[$];
    sb_t  stb_q[$];
    vec_t vecs[8];

    int n_vec = 0;
    int n_err = 0;
    int ecnt_m = 0;
    int edges = 0;
    int en_div = 1;
    int en_cnt = 0;
    int acks_seen = 0;
    int strobes_seen = 0;
    logic [7:0]  last_rd = 8'h00;
    logic        prev_ack = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [15:0] prev_sel = 16'h0;
    logic [19:0] prev_misc = 20'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    task automatic monitor(input logic en, input logic rst);
        logic        strobe;
        logic [19:0] misc;
        sb_t         it;
        strobe = (reg_sel != 16'h0) || wr || (bus_dout != 8'h0);
        misc   = {cpu_dout, bus_dout, ack, wr, eclk, e_phase};
        if (rst) begin
            ack_q.delete();
            stb_q.delete();
            last_rd = 8'h00;
            check("reset_sel", 32'(reg_sel), 32'h0);
            check("reset_misc", 32'(misc), 32'h0);
        end else begin
            check("eclk", 32'(eclk), 32'(ecnt_m == 9));
            check("e_phase", 32'(e_phase), 32'(ecnt_m >= 6));
            if (!en) begin
                check("stall_hold", 32'(misc), 32'(prev_misc));
                check("stall_sel", 32'(reg_sel), 32'(prev_sel));
            end
            if (strobe && !prev_strobe) begin
                strobes_seen++;
                if (stb_q.size() == 0) begin
                    fail_now("unexpected_strobe");
                end else begin
                    it = stb_q.pop_front();
                    check("strobe_sel", 32'(reg_sel), 32'(it.exp_sel));
                    check("strobe_wr", 32'(wr), 32'(it.exp_wr));
                    check("strobe_data", 32'(bus_dout), 32'(it.exp_bus));
                end
            end
            if (strobe) check("strobe_phase", 32'(ecnt_m), 32'd8);
            if (strobe && en) check("strobe_len", 32'(prev_strobe), 32'h0);
            if (ack && !prev_ack) begin
                acks_seen++;
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    it = ack_q.pop_front();
                    check("ack_latency", 32'(edges - it.req_edge), 32'(it.exp_lat));
                    check("cpu_dout", 32'(cpu_dout), 32'(it.exp_dout));
                end
            end
            if (ack && en) check("ack_len", 32'(prev_ack), 32'h0);
        end
        prev_ack    = ack;
        prev_strobe = strobe;
        prev_sel    = reg_sel;
        prev_misc   = misc;
    endtask

    // One clk period: reference E counter updated at the edge, DUT sampled
    // 1 time unit later, then clk7_en for the next edge is chosen.
    task automatic tick();
        logic en_at, rst_at;
        @(posedge clk);
        en_at  = clk7_en;
        rst_at = reset;
        if (reset) begin
            ecnt_m = 0;
        end else if (clk7_en) begin
            ecnt_m = (ecnt_m == 9) ? 0 : ecnt_m + 1;
            edges++;
        end
        #1;
        monitor(en_at, rst_at);
        en_cnt  = (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
        clk7_en = (en_cnt == 0);
    endtask

    // Wait until no access is outstanding, then one more enabled edge so the
    // sequencer has returned to IDLE.
    task automatic wait_idle();
        int guard = 0;
        int e0;
        while ((ack_q.size() != 0 || stb_q.size() != 0) && guard < 400) begin
            tick();
            guard++;
        end
        e0 = edges;
        while (edges == e0 && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) fail_now("idle_timeout");
    endtask

    task automatic push_req(input logic r, input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] bd, input int lat, input logic [15:0] sel);
        sb_t it;
        req     = 1'b1;
        rw      = r;
        addr    = a;
        cpu_din = d;
        bus_din = bd;
        it.req_edge = edges;
        it.exp_lat  = lat;
        it.exp_sel  = sel;
        it.exp_wr   = ~r;
        it.exp_bus  = r ? 8'h00 : d;
        it.exp_dout = r ? bd : last_rd;
        if (r) last_rd = bd;
        ack_q.push_back(it);
        stb_q.push_back(it);
    endtask

    task automatic wait_ecnt(input int target);
        int guard = 0;
        while (!(clk7_en && ecnt_m == target) && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) fail_now("align_timeout");
    endtask

    task automatic wait_ack();
        int guard = 0;
        int a0 = acks_seen;
        while (acks_seen == a0 && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) fail_now("ack_timeout");
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        wait_idle();
        wait_ecnt(v.start_ecnt);
`ifdef CIA_POSTED_WRITE_EN
        lat = v.rw ? v.exp_lat : 1;
`else
        lat = v.exp_lat;
`endif
        push_req(v.rw, v.addr, v.din, v.bdin, lat, v.exp_sel);
        wait_ack();
        req = 1'b0;
    endtask

    initial begin
        int c;
        int hi;
        int a0;
        int s0;
        reset   = 1'b1;
        clk7_en = 1'b1;
        req     = 1'b0;
        rw      = 1'b1;
        addr    = 4'h0;
        cpu_din = 8'h00;
        bus_din = 8'h00;

        //         rw    addr      din    bdin  ecnt lat  sel
        vecs[0] = '{1'b0, CIA_TALO, 8'h34, 8'h00, 0, 9,  16'h0010};
        vecs[1] = '{1'b1, CIA_CRA,  8'h00, 8'h5A, 0, 9,  16'h4000};
        vecs[2] = '{1'b0, CIA_TAHI, 8'h12, 8'h00, 7, 12, 16'h0020};
        vecs[3] = '{1'b1, CIA_TBLO, 8'h00, 8'hA5, 6, 3,  16'h0040};
        vecs[4] = '{1'b0, CIA_CRB,  8'h81, 8'h00, 8, 11, 16'h8000};
        vecs[5] = '{1'b1, CIA_TBHI, 8'h00, 8'h3C, 9, 10, 16'h0080};
        vecs[6] = '{1'b0, 4'h0,     8'hFF, 8'h00, 3, 6,  16'h0001};
        vecs[7] = '{1'b1, CIA_TALO, 8'h00, 8'hC3, 5, 4,  16'h0010};

        tick();
        tick();
        reset = 1'b0;

        // E clock after reset: first eclk in cycle 10, then every 10.
        c = 1;
        while (!eclk && c < 50) begin
            tick();
            c++;
        end
        check("eclk_first_cycle", 32'(c), 32'd10);
        c  = 0;
        hi = 0;
        do begin
            tick();
            c++;
            if (e_phase) hi++;
        end while (!eclk && c < 50);
        check("eclk_period", 32'(c), 32'd10);
        check("e_phase_width", 32'(hi), 32'd4);

        for (int pass = 0; pass < 2; pass++) begin
            en_div = (pass == 0) ? 1 : 4;
            for (int i = 0; i < 8; i++) begin
                run_vec(vecs[i]);
            end
        end

        // Reset while WAITing: no strobe and no ack afterwards.
        en_div = 1;
        wait_idle();
        wait_ecnt(0);
        push_req(1'b0, CIA_TALO, 8'h66, 8'h00, 9, 16'h0010);
        tick();
        tick();
        tick();
        reset = 1'b1;
        req   = 1'b0;
        tick();
        reset = 1'b0;
        a0 = acks_seen;
        s0 = strobes_seen;
        repeat (30) tick();
        check("abort_acks", 32'(acks_seen - a0), 32'd0);
        check("abort_strobes", 32'(strobes_seen - s0), 32'd0);

`ifdef CIA_POSTED_WRITE_EN
        // Posted write followed at once by a read: the read is not taken
        // until the write's ACCESS period has finished.
        wait_idle();
        wait_ecnt(0);
        push_req(1'b0, CIA_TAHI, 8'h77, 8'h00, 1, 16'h0020);
        wait_ack();
        push_req(1'b1, CIA_CRB, 8'h00, 8'h99, 18, 16'h8000);
        wait_ack();
        req = 1'b0;
`endif

        wait_idle();
        check("queues_drained", 32'(ack_q.size() + stb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
